video_eth_udp_pkt_tx: RTL and testbench
=======================================

// Module: video_eth_udp_pkt_tx
// PURPOSE
//  Video-to-UDP packetizer: the transmit-side source for the UDP/GMII engine. Packs one active
//  line of RGB888 pixels into one UDP payload and drives the engine's tx_start_en/tx_byte_num/
//  tx_req/tx_data handshake. It is the sender counterpart of the receive path that emits
//  rec_data_24 pixels. Two line buffers (ping-pong) let line N+1 fill while line N is sent.
// PARAMETERS
//  H_ACT     640      active pixels per line; must be a multiple of 4 (4 px -> 3 words)
//  HDR_TAG   8'hA5    tag byte in payload header word
//  LINE_WDS  H_ACT*3/4  derived: payload pixel words per line (localparam)
// PORTS
//  clk          in   1   single clock for pixel input and UDP tx engine (gmii_tx_clk domain)
//  rst          in   1   asynchronous reset, active-high
//  vs_in        in   1   frame-start pulse, 1 cycle, outside de_in
//  de_in        in   1   pixel valid, high for one active line
//  pix_in       in   24  {R,G,B} pixel, sampled when de_in=1
//  tx_start_en  out  1   1-cycle pulse: start one UDP packet
//  tx_byte_num  out  16  payload bytes = 4 + H_ACT*3, held stable while busy
//  tx_data      out  32  payload word, valid the cycle after tx_req
//  tx_req       in   1   engine requests next payload word
//  tx_done      in   1   engine finished packet (1-cycle pulse)
//  frame_cnt    out  8   frames seen (vs_in count, wraps 255->0)
//  drop_line    out  1   1-cycle pulse: a line was discarded
//  busy         out  1   high from tx_start_en until tx_done
// BEHAVIOUR
//  Reset: all outputs 0; both buffers empty; line_num=0; FSM=IDLE; tx_byte_num=0.
//  Write side: vs_in -> line_num=0, frame_cnt+=1. Rising de_in chooses the free buffer (alternating,
//   buf0 first after reset); if none free the whole line is dropped (drop_line at de fall).
//  Packing: bytes R0 G0 B0 R1 G1 B1 ... big-endian into 32b words: w0={R0,G0,B0,R1},
//   w1={G1,B1,R2,G2}, w2={B2,R3,G3,B3}; word written to buffer when 4 bytes accumulated.
//  At de_in fall: if exactly H_ACT pixels received -> buffer marked full with header
//   {HDR_TAG, frame_cnt, line_num}; else (short) buffer released, drop_line pulses. Pixels beyond
//   H_ACT are ignored (line still valid). line_num += 1 at every de fall (dropped or not).
//  Read FSM: IDLE -> START when a full buffer exists (oldest first); START: 1-cycle tx_start_en,
//   tx_byte_num = 4+H_ACT*3, busy=1 -> SEND. SEND: each tx_req returns next word next cycle:
//   word 0 = header, words 1..LINE_WDS = pixel words; after last word -> WAIT_DONE.
//   WAIT_DONE: on tx_done release buffer, busy=0 -> IDLE. tx_done in SEND also ends packet.
//  tx_req beyond LINE_WDS+1 words: tx_data=0, no pointer advance. tx_req outside SEND ignored.
//  Simultaneous: a buffer may be released (tx_done) and claimed by rising de_in in the same
//   cycle; the release takes effect first, so the line is accepted.
//  vs_in during de_in high: frame_cnt updates, current line completes with old header.
//  Reset mid-packet: immediate abort, all state cleared, no further tx_start_en until a new full line.
//  line_num is 16b and wraps; frame_cnt wraps modulo 256.
// TESTING
//  H_ACT=8, vs then one line pix=0x010203..0x161718 -> tx_start_en, tx_byte_num=28,
//   words A5_01_0000, 01020304, 05060708, ..., 15161718 on successive tx_req.
//  Two back-to-back lines, tx_req held low -> both buffered, zero drop_line; sent in line order 0,1.
//  Three lines with engine stalled -> third line dropped, drop_line=1 for one cycle, line_num=3 next.
//  Line with 5 pixels -> drop_line pulse, no tx_start_en, buffer reusable by next line.
//  tx_done same cycle as next line's de rise, both buffers full before -> new line accepted.
//  Assert rst during SEND -> busy=0, tx_start_en=0, frame_cnt=0 immediately; clean packet after.

Source files
------------

// File: rtl/video_eth_udp_pkt_tx.sv
// Video-to-UDP packetizer. Packs one active RGB888 line into one UDP payload
// (header word + H_ACT*3/4 pixel words) using ping-pong line buffers, and
// drives the UDP engine's start/req/data/done handshake.
module video_eth_udp_pkt_tx #(
  parameter int          H_ACT   = 640,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [23:0] pix_in,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic [7:0]  frame_cnt,
  output logic        drop_line,
  output logic        busy
);
  localparam int LINE_WDS = H_ACT * 3 / 4;
  localparam int MW = $clog2(LINE_WDS);        // buffer word index
  localparam int AW = $clog2(LINE_WDS + 2);    // read pointer: header + words + overrun
  localparam int PW = $clog2(H_ACT + 1);       // pixel counter
  localparam logic [15:0] BYTE_NUM = 16'(4 + H_ACT * 3);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [31:0] mem0 [0:LINE_WDS-1];
  logic [31:0] mem1 [0:LINE_WDS-1];

  logic            de_q, wr_act_q, wr_b_q, nxt_b_q, old_q, drop_q;
  logic [1:0]      full_q;
  logic [1:0][31:0] hdr_q;
  logic [31:0]     hdr_lat_q;
  logic [PW-1:0]   px_cnt_q;
  logic [1:0]      ph_q;
  logic [MW-1:0]   wa_q;
  logic [23:0]     acc_q;
  logic [7:0]      frame_q;
  logic [15:0]     line_q;
  logic [1:0]      state_q;
  logic            rd_sel_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [31:0]     tx_data_q;
  logic [15:0]     byte_num_q;

  logic rise, fall, release_w, claim_ok, claim_b, act_w, b_w, acc_en, wr_en, mark_full;
  logic [1:0]    free_w;
  logic [31:0]   wr_word, rd_word;
  logic [MW-1:0] rd_idx;

  assign rise      = de_in & ~de_q;
  assign fall      = ~de_in & de_q;
  assign release_w = tx_done && (state_q == S_SEND || state_q == S_WAIT);
  assign mark_full = fall && wr_act_q && (px_cnt_q == PW'(H_ACT));

  // A buffer is free if empty (or released this very cycle) and not being filled
  always_comb begin
    for (int b = 0; b < 2; b++)
      free_w[b] = (!full_q[b] || (release_w && rd_sel_q == 1'(b))) &&
                  !(wr_act_q && wr_b_q == 1'(b));
  end

  assign claim_ok = free_w[nxt_b_q] | free_w[~nxt_b_q];
  assign claim_b  = free_w[nxt_b_q] ? nxt_b_q : ~nxt_b_q;
  assign act_w    = rise ? claim_ok : wr_act_q;
  assign b_w      = rise ? claim_b : wr_b_q;
  assign acc_en   = de_in && act_w && (px_cnt_q < PW'(H_ACT));

  // Byte packer: acc_q holds the previous pixel; phase picks the leftover bytes
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    case (ph_q)
      2'd1:    begin wr_en = acc_en; wr_word = {acc_q[23:0], pix_in[23:16]}; end
      2'd2:    begin wr_en = acc_en; wr_word = {acc_q[15:0], pix_in[23:8]};  end
      2'd3:    begin wr_en = acc_en; wr_word = {acc_q[7:0],  pix_in};        end
      default: ;
    endcase
  end

  // Line buffer storage
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (b_w) mem1[wa_q] <= wr_word;
      else     mem0[wa_q] <= wr_word;
    end
  end

  // Write side: line claim, packing counters, buffer occupancy and ordering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= 1'b0; wr_act_q <= 1'b0; wr_b_q <= 1'b0; nxt_b_q <= 1'b0; old_q <= 1'b0;
      drop_q <= 1'b0; full_q <= '0; hdr_q <= '0; hdr_lat_q <= '0; px_cnt_q <= '0;
      ph_q <= '0; wa_q <= '0; acc_q <= '0; frame_q <= '0; line_q <= '0;
    end else begin
      de_q   <= de_in;
      drop_q <= fall && !mark_full;
      if (vs_in) begin
        frame_q <= frame_q + 8'd1;
        line_q  <= '0;
      end else if (fall) begin
        line_q  <= line_q + 16'd1;
      end
      if (rise) begin
        wr_act_q  <= claim_ok;
        wr_b_q    <= claim_b;
        hdr_lat_q <= {HDR_TAG, frame_q, line_q};
        if (claim_ok) nxt_b_q <= ~claim_b;
      end
      if (acc_en) begin
        acc_q    <= pix_in;
        ph_q     <= ph_q + 2'd1;
        px_cnt_q <= px_cnt_q + PW'(1);
      end
      if (wr_en) wa_q <= wa_q + MW'(1);
      // release first, so the surviving full buffer becomes the oldest
      if (release_w) begin
        full_q[rd_sel_q] <= 1'b0;
        old_q            <= ~rd_sel_q;
      end
      if (mark_full) begin
        full_q[wr_b_q] <= 1'b1;
        hdr_q[wr_b_q]  <= hdr_lat_q;
        if (!full_q[~wr_b_q] || (release_w && rd_sel_q == ~wr_b_q)) old_q <= wr_b_q;
      end
      if (fall) begin
        wr_act_q <= 1'b0;
        px_cnt_q <= '0;
        ph_q     <= '0;
        wa_q     <= '0;
      end
    end
  end

  assign rd_idx  = MW'(rd_ptr_q - AW'(1));
  assign rd_word = (rd_ptr_q == '0) ? hdr_q[rd_sel_q]
                 : (rd_sel_q ? mem1[rd_idx] : mem0[rd_idx]);

  // Read FSM: pick oldest full buffer, stream header + pixel words on tx_req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; rd_sel_q <= 1'b0; rd_ptr_q <= '0;
      tx_data_q <= '0; byte_num_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (|full_q) begin
          state_q    <= S_START;
          rd_sel_q   <= (&full_q) ? old_q : full_q[1];
          byte_num_q <= BYTE_NUM;
        end
        S_START: begin
          state_q  <= S_SEND;
          rd_ptr_q <= '0;
        end
        S_SEND: begin
          if (tx_done) state_q <= S_IDLE;
          else if (tx_req) begin
            tx_data_q <= rd_word;
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            if (rd_ptr_q == AW'(LINE_WDS)) state_q <= S_WAIT;
          end
        end
        default: begin
          if (tx_done)     state_q   <= S_IDLE;
          else if (tx_req) tx_data_q <= '0;
        end
      endcase
    end
  end

  assign tx_start_en = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign tx_byte_num = byte_num_q;
  assign tx_data     = tx_data_q;
  assign frame_cnt   = frame_q;
  assign drop_line   = drop_q;
endmodule

// File: tb/tb_video_eth_udp_pkt_tx.sv
// Directed bench for video_eth_udp_pkt_tx with H_ACT=8 (6 pixel words, 28 bytes).
module tb_video_eth_udp_pkt_tx;
  logic        clk = 1'b0;
  logic        rst, vs_in, de_in, tx_req, tx_done;
  logic [23:0] pix_in;
  logic        tx_start_en, drop_line, busy;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic [7:0]  frame_cnt;

  int checks = 0, passes = 0;
  int start_cnt = 0, start_used = 0, drop_cnt = 0;

  video_eth_udp_pkt_tx #(.H_ACT(8), .HDR_TAG(8'hA5)) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_data(tx_data),
    .tx_req(tx_req), .tx_done(tx_done), .frame_cnt(frame_cnt),
    .drop_line(drop_line), .busy(busy));

  always #5 clk = ~clk;

  // event counters sampled away from the active edge
  always @(negedge clk) begin
    if (tx_start_en) start_cnt++;
    if (drop_line)   drop_cnt++;
  end

  function automatic logic [7:0] pbyte(input logic [7:0] base, input int n);
    return base + 8'(n + 1);
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int j);
    int n;
    n = 4 * (j - 1);
    return {pbyte(base, n), pbyte(base, n + 1), pbyte(base, n + 2), pbyte(base, n + 3)};
  endfunction

  task automatic pulse_vs();
    @(posedge clk); #1 vs_in = 1'b1;
    @(posedge clk); #1 vs_in = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [7:0] base, input bit done_first);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      de_in  = 1'b1;
      pix_in = {pbyte(base, 3*k), pbyte(base, 3*k + 1), pbyte(base, 3*k + 2)};
      if (k == 0 && done_first) tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
    de_in = 1'b0; pix_in = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic read_pkt(input logic [31:0] hdr, input logic [7:0] base, input string nm);
    int t;
    logic [31:0] exp;
    t = 0;
    while (start_cnt <= start_used && t < 200) begin @(negedge clk); #1; t++; end
    checks++;
    if (start_cnt <= start_used) $display("FAIL %s_start: got no tx_start_en, expected one", nm);
    else passes++;
    start_used = start_cnt;
    checks++;
    if (tx_byte_num !== 16'd28) $display("FAIL %s_bytes: got %0d expected 28", nm, tx_byte_num);
    else passes++;
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk); #1 tx_req = 1'b1;
      @(posedge clk); #1 tx_req = 1'b0;
      @(negedge clk);
      exp = (j == 0) ? hdr : exp_word(base, j);
      checks++;
      if (tx_data !== exp) $display("FAIL %s_w%0d: got %h expected %h", nm, j, tx_data, exp);
      else passes++;
    end
  endtask

  task automatic finish_pkt(input string nm);
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_busy: got %b expected 0", nm, busy);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; vs_in = 0; de_in = 0; pix_in = '0; tx_req = 0; tx_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_start_en, busy, drop_line, frame_cnt, tx_byte_num, tx_data} !== '0)
      $display("FAIL reset_outs: got start=%b busy=%b drop=%b fc=%h bn=%h d=%h expected all 0",
               tx_start_en, busy, drop_line, frame_cnt, tx_byte_num, tx_data);
    else passes++;
    #1 rst = 1'b0;
  endtask

  task automatic test_single_line();
    pulse_vs();
    @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd1) $display("FAIL frame_cnt: got %0d expected 1", frame_cnt);
    else passes++;
    send_line(8, 8'h00, 0);
    read_pkt(32'hA501_0000, 8'h00, "single");
    // request past the last word returns zero
    @(posedge clk); #1 tx_req = 1'b1;
    @(posedge clk); #1 tx_req = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_data !== 32'h0) $display("FAIL overrun_data: got %h expected 0", tx_data);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL wait_busy: got %b expected 1", busy);
    else passes++;
    finish_pkt("single");
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = drop_cnt;
    send_line(8, 8'h40, 0);
    send_line(8, 8'h80, 0);
    checks++;
    if (drop_cnt != d0) $display("FAIL b2b_drop: got %0d drops expected 0", drop_cnt - d0);
    else passes++;
    read_pkt(32'hA501_0001, 8'h40, "b2b0");
    finish_pkt("b2b0");
    read_pkt(32'hA501_0002, 8'h80, "b2b1");
    finish_pkt("b2b1");
  endtask

  task automatic test_overflow_drop();
    int d0;
    d0 = drop_cnt;
    send_line(8, 8'h10, 0);   // line 3
    send_line(8, 8'h20, 0);   // line 4
    send_line(8, 8'h30, 0);   // line 5, no free buffer
    checks++;
    if (drop_cnt - d0 != 1) $display("FAIL ovf_drop: got %0d drop cycles expected 1", drop_cnt - d0);
    else passes++;
    read_pkt(32'hA501_0003, 8'h10, "ovf0");
    finish_pkt("ovf0");
    read_pkt(32'hA501_0004, 8'h20, "ovf1");
    finish_pkt("ovf1");
    send_line(8, 8'h50, 0);   // line 6: line_num advanced over the dropped line
    read_pkt(32'hA501_0006, 8'h50, "ovf2");
    finish_pkt("ovf2");
  endtask

  task automatic test_short_line();
    int d0, s0;
    d0 = drop_cnt; s0 = start_cnt;
    send_line(5, 8'h60, 0);   // line 7, short
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (drop_cnt - d0 != 1) $display("FAIL short_drop: got %0d expected 1", drop_cnt - d0);
    else passes++;
    checks++;
    if (start_cnt != s0) $display("FAIL short_nostart: got %0d starts expected 0", start_cnt - s0);
    else passes++;
    send_line(8, 8'h70, 0);   // line 8
    read_pkt(32'hA501_0008, 8'h70, "short_next");
    finish_pkt("short_next");
  endtask

  task automatic test_simultaneous();
    int d0;
    d0 = drop_cnt;
    send_line(8, 8'h90, 0);   // line 9
    send_line(8, 8'hA0, 0);   // line 10
    read_pkt(32'hA501_0009, 8'h90, "sim0");
    send_line(8, 8'hB0, 1);   // line 11 rises with tx_done of line 9
    checks++;
    if (drop_cnt != d0) $display("FAIL sim_drop: got %0d drops expected 0", drop_cnt - d0);
    else passes++;
    read_pkt(32'hA501_000A, 8'hA0, "sim1");
    finish_pkt("sim1");
    read_pkt(32'hA501_000B, 8'hB0, "sim2");
    finish_pkt("sim2");
  endtask

  task automatic test_reset_mid();
    int s0;
    send_line(8, 8'hC0, 0);
    @(negedge clk);
    // move into SEND and fetch two words
    repeat (4) @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1 tx_req = 1'b1;
      @(posedge clk); #1 tx_req = 1'b0;
    end
    start_used = start_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, tx_start_en, frame_cnt, tx_byte_num} !== '0)
      $display("FAIL rst_mid: got busy=%b start=%b fc=%0d bn=%0d expected all 0",
               busy, tx_start_en, frame_cnt, tx_byte_num);
    else passes++;
    @(posedge clk); #1 rst = 1'b0;
    s0 = start_cnt;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_cnt != s0) $display("FAIL rst_nostart: got %0d starts expected 0", start_cnt - s0);
    else passes++;
    start_used = start_cnt;
    pulse_vs();
    send_line(8, 8'hD0, 0);
    read_pkt(32'hA501_0000, 8'hD0, "rst_after");
    finish_pkt("rst_after");
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_back_to_back();
    test_overflow_drop();
    test_short_line();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
